// File: rtl/seg7_scan_driver.sv
// Purpose: time-multiplexed NUM_DIGITS hex 7-segment driver with tear-free double buffering, blanking, error override.
// Latency: pins are registered from the current index/display state, so an index change reaches the pins 1 clk later.
// Backpressure: none; value_in is sampled only on load and the scan free-runs.
module seg7_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic                    err,
  output logic [0:6]              segments,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  // Polarity masks applied just before the output registers, so reset values follow them too.
  localparam logic [6:0] SEG_INV = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_INV = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic [6:0] SEG_E = 7'b1001111;

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] pending;
  logic                    pending_valid;
  logic [4*NUM_DIGITS-1:0] display;
  logic                    wrapped;

  logic                    tick;
  logic                    wrap;
  logic [3:0]              nibble;
  logic                    blank;
  logic                    upper_zero;
  logic [NUM_DIGITS-1:0]   sel;
  logic [6:0]              seg_lit;

  // Hex nibble to a..g pattern, bit 6 = a, lit = 1.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  assign tick = (cnt == CNT_LAST);
  assign wrap = tick && (idx == IDX_LAST);

  // Select the current digit's nibble, its one-hot enable and whether it is a leading zero.
  always_comb begin
    nibble     = 4'h0;
    sel        = '0;
    blank      = 1'b0;
    upper_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nibble = display[4*i +: 4];
        sel[i] = 1'b1;
      end
    end
    // Walk from the top digit down; a digit is a leading zero if it and everything above it is zero.
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero && (display[4*i +: 4] == 4'h0);
      if ((idx == IW'(i)) && upper_zero) blank = 1'b1;
    end
  end

  // Segment pattern before polarity: error beats blanking beats decode.
  always_comb begin
    seg_lit = hex_to_seg(nibble);
    if (err) seg_lit = SEG_E;
    else if (blank_lz && blank) seg_lit = 7'b0000000;
  end

  // Scan counters and the pending/display double buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      idx           <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      display       <= '0;
      wrapped       <= 1'b0;
    end else begin
      cnt     <= tick ? '0 : cnt + CW'(1);
      wrapped <= wrap;
      if (tick) idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      // A load landing on the wrap bypasses pending and supersedes any older pending value.
      if (wrap && load) begin
        display       <= value_in;
        pending_valid <= 1'b0;
      end else if (wrap && pending_valid) begin
        display       <= pending;
        pending_valid <= 1'b0;
      end else if (load) begin
        pending       <= value_in;
        pending_valid <= 1'b1;
      end
    end
  end

  // Registered pins; frame_done lines up with the first output cycle of digit 0 after a wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      segments   <= SEG_INV;
      digit_en   <= AN_INV;
      frame_done <= 1'b0;
    end else begin
      segments   <= seg_lit ^ SEG_INV;
      digit_en   <= sel ^ AN_INV;
      frame_done <= wrapped;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (4 digits, 4 clk per digit, default polarity).
// Expected pin words are queued per frame when stimulus is set up and popped every output cycle.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value_in;
  logic        load;
  logic        blank_lz;
  logic        err;
  logic [0:6]  segments;
  logic [3:0]  digit_en;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int step_no = 0;
  logic [11:0] exp_q[$];

  seg7_scan_driver #(
    .NUM_DIGITS(4),
    .REFRESH_DIV(4),
    .SEG_ACTIVE_LOW(0),
    .AN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .value_in(value_in),
    .load(load),
    .blank_lz(blank_lz),
    .err(err),
    .segments(segments),
    .digit_en(digit_en),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1111110; 4'h1: s = 7'b0110000; 4'h2: s = 7'b1101101; 4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011; 4'h5: s = 7'b1011011; 4'h6: s = 7'b1011111; 4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111; 4'h9: s = 7'b1111011; 4'hA: s = 7'b1110111; 4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110; 4'hD: s = 7'b0111101; 4'hE: s = 7'b1001111; default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed seg/an/fd=%b expected %b", tag, obs, expv);
    end
  endtask

  // Expected pin word {segments a..g, digit_en pins, frame_done} for output cycle c of a frame.
  task automatic push_cycle(input logic [15:0] v, input logic blz, input logic e,
                            input int c, input logic fd_first);
    int d;
    logic [6:0] s;
    logic [3:0] an;
    logic [15:0] upper;
    d = c / 4;
    upper = v >> (4 * d);
    if (e) s = 7'b1001111;
    else if (blz && d > 0 && upper == 16'h0) s = 7'b0000000;
    else s = ref_seg(upper[3:0]);
    an = ~(4'b0001 << d);
    exp_q.push_back({s, an, fd_first && (c == 0)});
  endtask

  task automatic push_frame(input logic [15:0] v, input logic blz, input logic e, input logic fd_first);
    for (int c = 0; c < 16; c++) push_cycle(v, blz, e, c, fd_first);
  endtask

  task automatic step();
    logic [11:0] expv;
    @(posedge clk);
    #1;
    step_no++;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty@%0d: observed %b expected queued entry", step_no,
             {segments, digit_en, frame_done});
    end else begin
      expv = exp_q.pop_front();
      check($sformatf("scan@%0d", step_no), {segments, digit_en, frame_done}, expv);
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1;
    value_in = v;
    step();
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; value_in = 16'h0; blank_lz = 1'b0; err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {segments, digit_en, frame_done}, {7'b0000000, 4'b1111, 1'b0});
    rst = 1'b0;

    // Frame A: power-up frame of zeros; a mid-frame load must not tear it.
    push_frame(16'h0000, 1'b0, 1'b0, 1'b0);
    repeat (5) step();
    do_load(16'h12AF);
    repeat (10) step();

    // Frame B: pending value applied at the wrap; load on the wrap edge itself.
    push_frame(16'h12AF, 1'b0, 1'b0, 1'b1);
    repeat (15) step();
    do_load(16'h0003);

    // Frame C: shows 0003 immediately; two loads, only the later must survive.
    push_frame(16'h0003, 1'b0, 1'b0, 1'b1);
    repeat (3) step();
    do_load(16'h1111);
    repeat (4) step();
    do_load(16'h2222);
    repeat (7) step();

    // Frame D: 2222, then load 0030 on the wrap and enable blanking.
    push_frame(16'h2222, 1'b0, 1'b0, 1'b1);
    repeat (15) step();
    do_load(16'h0030);
    blank_lz = 1'b1;

    // Frame E: leading-zero blanking of 0030.
    push_frame(16'h0030, 1'b1, 1'b0, 1'b1);
    repeat (15) step();
    do_load(16'h0000);

    // Frame F: all-zero value shows a single 0.
    push_frame(16'h0000, 1'b1, 1'b0, 1'b1);
    repeat (15) step();
    do_load(16'hBEEF);
    err = 1'b1;

    // Frame G: error override on every digit.
    push_frame(16'hBEEF, 1'b1, 1'b1, 1'b1);
    repeat (16) step();
    err = 1'b0;

    // Frame H: normal decode resumes.
    push_frame(16'hBEEF, 1'b1, 1'b0, 1'b1);
    repeat (16) step();

    // Frame I: queue a pending value, reset while scanning digit 2.
    for (int c = 0; c < 9; c++) push_cycle(16'hBEEF, 1'b1, 1'b0, c, 1'b1);
    repeat (2) step();
    do_load(16'h5555);
    repeat (6) step();
    rst = 1'b1;
    exp_q.push_back({7'b0000000, 4'b1111, 1'b0});
    step();
    rst = 1'b0;
    blank_lz = 1'b0;

    // Frames J, K: scan restarts at digit 0 with zeros; the discarded pending value never shows.
    push_frame(16'h0000, 1'b0, 1'b0, 1'b0);
    repeat (16) step();
    push_frame(16'h0000, 1'b0, 1'b0, 1'b1);
    repeat (16) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
